// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, injector FSM states, node-ID width helper.
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } inj_state_t;

  // A single-node network still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Valid/ready output register: one cycle from load to valid; holds while valid && !ready.
// can_load is high when the slot is empty or draining this cycle, so loads never stall a full link.
module flit_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         can_load,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_injector.sv
// Local injection port: turns a request plus payload words into HEAD/BODY.../TAIL flits, 1-cycle latency.
// Source readys follow the output slot, so router backpressure stalls both request and word inputs.
module packet_injector
  import noc_pkg::*;
#(
  parameter  int N             = 4,
  parameter  int INDEX         = 1,
  parameter  int DATA_WIDTH    = 8,
  parameter  int TYPE_WIDTH    = 2,
  parameter  int FlitPerPacket = 6,
  localparam int IDW           = id_width(N),
  localparam int PW            = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [IDW-1:0]        pkt_dest,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [PW-1:0]         word_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  busy
);

  localparam int CW = (FlitPerPacket <= 2) ? 1 : $clog2(FlitPerPacket);
  localparam logic [IDW-1:0] SRC_ID    = IDW'(INDEX);
  localparam logic [CW-1:0]  LAST_BODY = CW'(FlitPerPacket - 2);

  inj_state_t            state;
  logic [CW-1:0]         cnt;
  logic                  can_load;
  logic                  pkt_fire;
  logic                  word_fire;
  logic                  is_tail;
  logic [PW-1:0]         head_pl;
  logic [TYPE_WIDTH-1:0] word_type;
  logic [DATA_WIDTH-1:0] flit_in;

  assign pkt_ready  = (state == ST_IDLE) && can_load;
  assign word_ready = (state == ST_PAYLOAD) && can_load;
  assign pkt_fire   = pkt_valid && pkt_ready;
  assign word_fire  = word_valid && word_ready;

  // cnt counts payload words already sent; the word at cnt == FlitPerPacket-2 closes the packet.
  assign is_tail   = (cnt >= LAST_BODY);
  assign word_type = is_tail ? TYPE_WIDTH'(FLIT_TAIL) : TYPE_WIDTH'(FLIT_BODY);
  assign head_pl   = PW'({pkt_dest, SRC_ID}) << (PW - 2 * IDW);
  assign flit_in   = pkt_fire ? {TYPE_WIDTH'(FLIT_HEAD), head_pl} : {word_type, word_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pkt_fire) begin
            state <= ST_PAYLOAD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (word_fire) begin
            cnt <= cnt + 1'b1;
            if (is_tail) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  flit_out_reg #(
    .W(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (pkt_fire || word_fire),
    .load_data(flit_in),
    .can_load (can_load),
    .valid    (valid_out),
    .data     (data_out),
    .ready    (ready_out)
  );

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: stimulus pushes hand-computed flits, a monitor pops and compares.
module tb_packet_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [1:0] pkt_dest;
  logic       word_valid;
  logic       word_ready;
  logic [5:0] word_data;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_out;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int         xfer_q[$];

  packet_injector #(
    .N(4), .INDEX(1), .DATA_WIDTH(8), .TYPE_WIDTH(2), .FlitPerPacket(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dest  (pkt_dest),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data (word_data),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every transfer on the link must match the oldest expected flit.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      xfer_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_flit: got 0x%0h, expected no flit", data_out);
      end else begin
        chk("flit", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic offer_pkt(input logic [1:0] d);
    int n = 0;
    pkt_valid = 1'b1;
    pkt_dest  = d;
    @(negedge clk);
    while (!pkt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_accept", {31'h0, pkt_ready}, 32'd1);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic offer_word(input logic [5:0] w);
    int n = 0;
    word_valid = 1'b1;
    word_data  = w;
    @(negedge clk);
    while (!word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("word_accept", {31'h0, word_ready}, 32'd1);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic push6(input logic [7:0] a, b, c, d, e, f);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    exp_q.push_back(d); exp_q.push_back(e); exp_q.push_back(f);
  endtask

  task automatic words5(input logic [5:0] a, b, c, d, e);
    offer_word(a); offer_word(b); offer_word(c); offer_word(d); offer_word(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; pkt_dest = '0;
    word_valid = 1'b0; word_data = '0; ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid_out", {31'h0, valid_out}, 32'd0);
    chk("rst_data_out", {24'h0, data_out}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_pkt_ready", {31'h0, pkt_ready}, 32'd1);
    chk("rst_word_ready", {31'h0, word_ready}, 32'd0);

    // 1: single packet, no backpressure
    @(posedge clk); #1;
    xfer_q.delete();
    push6(8'h74, 8'h95, 8'h96, 8'h97, 8'h98, 8'hEA);
    offer_pkt(2'd3);
    chk("busy_after_head", {31'h0, busy}, 32'd1);
    words5(6'h15, 6'h16, 6'h17, 6'h18, 6'h2A);
    @(negedge clk);
    chk("busy_after_tail", {31'h0, busy}, 32'd0);
    wait_drain();
    chk("t1_count", xfer_q.size(), 32'd6);
    if (xfer_q.size() == 6) chk("t1_span", xfer_q[5] - xfer_q[0], 32'd5);

    // 2: backpressure on the head flit
    @(posedge clk); #1;
    ready_out = 1'b0;
    push6(8'h74, 8'h95, 8'h96, 8'h97, 8'h98, 8'hEA);
    offer_pkt(2'd3);
    word_valid = 1'b1;
    word_data  = 6'h15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, valid_out}, 32'd1);
      chk("bp_data", {24'h0, data_out}, 32'h74);
      chk("bp_word_ready", {31'h0, word_ready}, 32'd0);
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    words5(6'h15, 6'h16, 6'h17, 6'h18, 6'h2A);
    wait_drain();

    // 3: back-to-back packets, no bubbles
    @(posedge clk); #1;
    xfer_q.delete();
    push6(8'h74, 8'h95, 8'h96, 8'h97, 8'h98, 8'hEA);
    push6(8'h44, 8'h81, 8'h82, 8'h83, 8'h84, 8'hFF);
    offer_pkt(2'd3);
    words5(6'h15, 6'h16, 6'h17, 6'h18, 6'h2A);
    offer_pkt(2'd0);
    words5(6'h01, 6'h02, 6'h03, 6'h04, 6'h3F);
    wait_drain();
    chk("t3_count", xfer_q.size(), 32'd12);
    if (xfer_q.size() == 12) chk("t3_span", xfer_q[11] - xfer_q[0], 32'd11);

    // 4: word starvation mid-packet
    @(posedge clk); #1;
    push6(8'h74, 8'h95, 8'h96, 8'h97, 8'h98, 8'hEA);
    offer_pkt(2'd3);
    offer_word(6'h15);
    offer_word(6'h16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_valid", {31'h0, valid_out}, (i == 0) ? 32'd1 : 32'd0);
      chk("starve_busy", {31'h0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    offer_word(6'h17);
    offer_word(6'h18);
    offer_word(6'h2A);
    wait_drain();

    // 5: reset after the third flit
    @(posedge clk); #1;
    exp_q.push_back(8'h74); exp_q.push_back(8'h95); exp_q.push_back(8'h96);
    offer_pkt(2'd3);
    offer_word(6'h15);
    offer_word(6'h16);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, valid_out}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    chk("mid_rst_pkt_ready", {31'h0, pkt_ready}, 32'd1);
    chk("mid_rst_word_ready", {31'h0, word_ready}, 32'd0);
    chk("mid_rst_pending", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    push6(8'h64, 8'h81, 8'h82, 8'h83, 8'h84, 8'hFF);
    offer_pkt(2'd2);
    words5(6'h01, 6'h02, 6'h03, 6'h04, 6'h3F);
    wait_drain();

    // 6: words offered while idle are not taken
    @(posedge clk); #1;
    word_valid = 1'b1;
    word_data  = 6'h2A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_word_ready", {31'h0, word_ready}, 32'd0);
      chk("idle_valid_out", {31'h0, valid_out}, 32'd0);
      @(posedge clk); #1;
    end
    word_valid = 1'b0;
    repeat (2) @(posedge clk);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
# packet_injector

Network-interface transmitter that builds packets and feeds them into a router input port. It accepts a packet request (destination) and a stream of payload words from the local core. It emits a head flit followed by `FlitPerPacket-1` payload flits, the last marked tail, over the router's valid/ready flit link. One instance sits at each node's local injection port.

## Interface
- `N`, 4: number of nodes; node-ID width `IDW = $clog2(N)`.
- `INDEX`, 1: this node's ID, inserted as the source field of every head flit.
- `DATA_WIDTH`, 8: flit width on the link.
- `TYPE_WIDTH`, 2: flit-type field width, occupying flit bits `[DATA_WIDTH-1 -: TYPE_WIDTH]`.
- `FlitPerPacket`, 6: total flits per packet including head; must be ≥ 2.
- `PW = DATA_WIDTH-TYPE_WIDTH`: payload field width; `2*IDW ≤ PW` is required.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: packet request valid.
- `pkt_ready` out 1: packet request accepted when both valid and ready are high.
- `pkt_dest` in IDW: destination node ID.
- `word_valid` in 1: payload word valid.
- `word_ready` out 1: payload word accepted when both valid and ready are high.
- `word_data` in PW: payload word.
- `data_out` out DATA_WIDTH: flit to the router port.
- `valid_out` out 1: flit valid.
- `ready_out` in 1: router port ready; the flit transfers when `valid_out && ready_out`.
- `busy` out 1: high from packet acceptance until the tail flit is loaded into the output register.

## Operation
- Flit type encoding: 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL, 2'b00 never emitted.
- Head payload: `{pkt_dest, INDEX[IDW-1:0], zeros}`, with the destination in the MSBs.
- Payload flit: `{type, word_data}`.
- FSM states:
  - **IDLE**: `pkt_ready = !valid_out || ready_out`. On accept, the head flit is loaded into the output register, `cnt` ← 0, and the FSM moves to PAYLOAD.
  - **PAYLOAD**: `word_ready = !valid_out || ready_out`.
    - On each accepted word, the flit is loaded into the output register and `cnt` increments.
    - The type is BODY while `cnt < FlitPerPacket-2`, else TAIL.
    - After the TAIL word is loaded, the FSM returns to IDLE.
- `word_ready` is 0 in IDLE, and `pkt_ready` is 0 in PAYLOAD. Words offered in IDLE are ignored; they are held by the upstream source, not dropped.
- Output register:
  - `valid_out`/`data_out` stay stable while `valid_out && !ready_out`.
  - It clears when the flit transfers and no new flit is loaded that cycle.
- `cnt` width is `$clog2(FlitPerPacket)`; it never wraps within a packet.
- The block adds no bubbles: if `ready_out` and the sources are continuously high, one flit transfers per cycle, including tail→next head.

## Timing
- Reset values: `valid_out` 0, `data_out` 0, `busy` 0, FSM in IDLE, `cnt` 0. This gives `pkt_ready` 1 and `word_ready` 0 in the cycle after reset deasserts.
- Latency: a request or word accepted in cycle T appears on `valid_out`/`data_out` in cycle T+1.
- Packet length: a packet occupies exactly `FlitPerPacket` flit transfers. Minimum packet time is `FlitPerPacket` cycles.
- Backpressure: with `ready_out` low, both source readys are 0 while `valid_out` is 1, and the output holds.
- Simultaneous transfer and load: when the output flit transfers and a new flit is loaded in the same cycle, the new flit is valid in the next cycle with no gap.
- Reset mid-packet:
  - The partial packet is abandoned, `valid_out` drops in the next cycle, and the FSM goes to IDLE.
  - The downstream port must also be reset; this is a system requirement.

## Structure
- Shared package `noc_pkg`:
  - Flit-type localparams `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`.
  - FSM state encoding.
  - Width helper for the node ID.
- One sub-module, `flit_out_reg`: a valid/ready pipeline register with load and hold, reusable on other link outputs.

## Test plan
Common configuration: N=4, INDEX=1, DATA_WIDTH=8, TYPE_WIDTH=2, FlitPerPacket=6.

1. **Single packet, no backpressure.** Packet with dest=3, words 0x15,0x16,0x17,0x18,0x2A, `ready_out` held 1 → flits 0x74, 0x95, 0x96, 0x97, 0x98, 0xEA on 6 consecutive cycles, each starting one cycle after its accept.
2. **Backpressure.** Same packet, `ready_out` low for 3 cycles while the head is valid → `data_out` stays 0x74 throughout, `word_ready`=0, and the remaining stream is unchanged.
3. **Back-to-back packets.** Two packets (dest 3, then dest 0), all sources and `ready_out` always high → 12 flits in 12 cycles. Second head is 0x44 and follows the first tail (0xEA) with no gap.
4. **Word starvation.** `word_valid` low for 5 cycles mid-packet → `valid_out` drops after the pending flit transfers, `busy` stays 1, and the packet resumes correctly with the tail count intact.
5. **Reset mid-packet.** Assert `rst` after the 3rd flit → next cycle `valid_out`=0, `busy`=0, `pkt_ready`=1. A new packet then starts with a HEAD flit.
6. **Idle words.** `word_valid`=1 in IDLE → `word_ready` stays 0 and no flit is emitted.
